// File: rtl/tag_pipe_sync_if.sv
// Bus bundle for tag_pipe_sync: the producer allocation port, the load, compute
// and store stage handshakes, and the occupancy status.
// The master drives the requests and done pulses. The slave (the tag pipe) drives
// the ready/tag/status outputs.
interface tag_pipe_sync_if #(
  parameter int NUM_TAGS  = 2,
  parameter int NUM_LD_CH = 1,
  parameter int TAG_W     = $clog2(NUM_TAGS),
  parameter int OCC_W     = $clog2(NUM_TAGS + 1)
);
  // Allocation port
  logic                 alloc_req;
  logic                 alloc_reuse;
  logic                 alloc_ready;
  logic [TAG_W-1:0]     alloc_tag;
  logic                 alloc_hit;

  // Load stage
  logic [NUM_LD_CH-1:0] ld_done;
  logic                 ld_ready;
  logic [TAG_W-1:0]     ld_tag;

  // Compute stage
  logic                 cmp_done;
  logic                 cmp_ready;
  logic [TAG_W-1:0]     cmp_tag;

  // Store stage
  logic                 st_done;
  logic                 st_ready;
  logic [TAG_W-1:0]     st_tag;

  // Status
  logic [OCC_W-1:0]     occupancy;
  logic                 all_idle;

  modport master (
    output alloc_req, alloc_reuse, ld_done, cmp_done, st_done,
    input  alloc_ready, alloc_tag, alloc_hit, ld_ready, ld_tag,
           cmp_ready, cmp_tag, st_ready, st_tag, occupancy, all_idle
  );

  modport slave (
    input  alloc_req, alloc_reuse, ld_done, cmp_done, st_done,
    output alloc_ready, alloc_tag, alloc_hit, ld_ready, ld_tag,
           cmp_ready, cmp_tag, st_ready, st_tag, occupancy, all_idle
  );
endinterface

// File: rtl/tag_pipe_sync.sv
// tag_pipe_sync: in-order buffer-tag sequencer.
// Each tag walks through FREE -> LOAD -> CMP_RDY <-> COMPUTE -> STORE -> FREE.
// Four round-robin pointers (alloc, load, compute, store) keep the tags in order.
// A producer may reuse the most recently allocated tag while its data is still
// resident. Each reuse adds one pending compute pass to that tag's counter.
module tag_pipe_sync #(
  parameter int NUM_TAGS      = 2,
  parameter int TAG_W         = $clog2(NUM_TAGS),
  parameter int NUM_LD_CH     = 1,
  parameter bit STORE_ENABLED = 1'b1,
  parameter int REUSE_CNT_W   = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  tag_pipe_sync_if.slave bus
);

  localparam int OCC_W = $clog2(NUM_TAGS + 1);

  typedef enum logic [2:0] {
    ST_FREE,
    ST_LOAD,
    ST_CMP_RDY,
    ST_COMPUTE,
    ST_STORE
  } tag_state_e;

  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [REUSE_CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {REUSE_CNT_W{1'b1}};

  // Per-tag state and pending-compute counters
  tag_state_e state_q [NUM_TAGS];
  tag_state_e state_d [NUM_TAGS];
  cnt_t       cnt_q   [NUM_TAGS];
  cnt_t       cnt_d   [NUM_TAGS];

  // Stage pointers and bookkeeping
  tag_t                 alloc_ptr_q, alloc_ptr_d;
  tag_t                 ld_ptr_q,    ld_ptr_d;
  tag_t                 cmp_ptr_q,   cmp_ptr_d;
  tag_t                 st_ptr_q,    st_ptr_d;
  tag_t                 prev_tag_q,  prev_tag_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [NUM_LD_CH-1:0] ld_mask_q,   ld_mask_d;

  // Decoded events for this cycle
  logic                 reuse_hit;
  logic                 alloc_accept;
  logic                 cmp_fire;
  logic [NUM_LD_CH-1:0] ld_seen;
  logic [OCC_W-1:0]     occ_cnt;

  // Pointer increment. It wraps after NUM_TAGS-1, which need not be a power of two.
  function automatic tag_t next_ptr(input tag_t p);
    return (p == tag_t'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register: tag array, pointers, load mask and reuse tracking
  // NOTE: the tag array is a handful of flops rather than a RAM. Resetting every
  // entry is what makes reset discard in-flight tags at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        state_q[t] <= ST_FREE;
        cnt_q[t]   <= '0;
      end
      alloc_ptr_q  <= '0;
      ld_ptr_q     <= '0;
      cmp_ptr_q    <= '0;
      st_ptr_q     <= '0;
      prev_tag_q   <= '0;
      prev_valid_q <= 1'b0;
      ld_mask_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples the values from before this edge.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alloc_ptr_q  <= alloc_ptr_d;
      ld_ptr_q     <= ld_ptr_d;
      cmp_ptr_q    <= cmp_ptr_d;
      st_ptr_q     <= st_ptr_d;
      prev_tag_q   <= prev_tag_d;
      prev_valid_q <= prev_valid_d;
      ld_mask_q    <= ld_mask_d;
    end
  end

  // Next-state: apply the allocate, load, compute and store transitions
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    alloc_ptr_d  = alloc_ptr_q;
    ld_ptr_d     = ld_ptr_q;
    cmp_ptr_d    = cmp_ptr_q;
    st_ptr_d     = st_ptr_q;
    prev_tag_d   = prev_tag_q;
    prev_valid_d = prev_valid_q;
    ld_mask_d    = ld_mask_q;

    alloc_accept = bus.alloc_req && bus.alloc_ready;
    cmp_fire     = bus.cmp_done && (state_q[cmp_ptr_q] == ST_COMPUTE);
    ld_seen      = ld_mask_q | bus.ld_done;

    // Counter updates are applied in order. A reuse and a compute completion on
    // the same tag then cancel, leaving that tag's count unchanged.
    // NOTE: blocking assignments here make the second update see the first.
    if (alloc_accept && reuse_hit) begin
      cnt_d[prev_tag_q] = cnt_d[prev_tag_q] + 1'b1;
    end
    if (cmp_fire) begin
      cnt_d[cmp_ptr_q] = cnt_d[cmp_ptr_q] - 1'b1;
    end

    // Fresh allocation claims the FREE tag at alloc_ptr
    if (alloc_accept && !reuse_hit) begin
      state_d[alloc_ptr_q] = ST_LOAD;
      cnt_d[alloc_ptr_q]   = cnt_t'(1);
      prev_tag_d           = alloc_ptr_q;
      prev_valid_d         = 1'b1;
      alloc_ptr_d          = next_ptr(alloc_ptr_q);
    end

    // The load completes once every channel has reported, in any order
    if (bus.ld_ready) begin
      if (&ld_seen) begin
        state_d[ld_ptr_q] = ST_CMP_RDY;
        ld_mask_d         = '0;
        ld_ptr_d          = next_ptr(ld_ptr_q);
      end else begin
        ld_mask_d = ld_seen;
      end
    end

    // Compute: a ready tag starts on this edge. On completion the tag either
    // loops back for another pass or retires.
    if (bus.cmp_ready) begin
      state_d[cmp_ptr_q] = ST_COMPUTE;
    end else if (cmp_fire) begin
      if (cnt_d[cmp_ptr_q] != '0) begin
        state_d[cmp_ptr_q] = ST_CMP_RDY;
      end else begin
        state_d[cmp_ptr_q] = STORE_ENABLED ? ST_STORE : ST_FREE;
        cmp_ptr_d          = next_ptr(cmp_ptr_q);
      end
    end

    // Store completion releases the tag
    if (bus.st_ready && bus.st_done) begin
      state_d[st_ptr_q] = ST_FREE;
      st_ptr_d          = next_ptr(st_ptr_q);
    end
  end

  // Outputs: grant decision, stage readies, occupancy, all decoded from the state array
  always_comb begin
    reuse_hit = bus.alloc_reuse && prev_valid_q
             && (state_q[prev_tag_q] inside {ST_LOAD, ST_CMP_RDY, ST_COMPUTE})
             && (cnt_q[prev_tag_q] != CNT_MAX);

    bus.alloc_hit   = reuse_hit;
    bus.alloc_tag   = reuse_hit ? prev_tag_q : alloc_ptr_q;
    bus.alloc_ready = reuse_hit || (state_q[alloc_ptr_q] == ST_FREE);

    bus.ld_tag    = ld_ptr_q;
    bus.ld_ready  = (state_q[ld_ptr_q] == ST_LOAD);
    bus.cmp_tag   = cmp_ptr_q;
    bus.cmp_ready = (state_q[cmp_ptr_q] == ST_CMP_RDY);
    bus.st_tag    = st_ptr_q;
    bus.st_ready  = STORE_ENABLED && (state_q[st_ptr_q] == ST_STORE);

    occ_cnt = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (state_q[t] != ST_FREE) begin
        occ_cnt = occ_cnt + 1'b1;
      end
    end
    bus.occupancy = occ_cnt;
    bus.all_idle  = (occ_cnt == '0);
  end

endmodule

// File: tb/tb_tag_pipe_sync.sv
// Directed bench for tag_pipe_sync.
// The main instance uses 2 tags, 3 load channels and the store stage enabled.
// A second instance uses 1 load channel and the store stage disabled.
// Expected grants and store tags are queued when stimulus is driven, then
// popped and compared when the design presents them.
// Inputs change on the falling clock edge; outputs are sampled 1 ns later.
module tb_tag_pipe_sync;
  localparam int NT  = 2;
  localparam int LDC = 3;
  localparam int TW  = $clog2(NT);

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic          hit;
  } grant_t;

  grant_t        grant_q [$];
  logic [TW-1:0] store_q [$];

  always #5 clk = ~clk;

  tag_pipe_sync_if #(.NUM_TAGS(NT), .NUM_LD_CH(LDC)) bus ();
  tag_pipe_sync_if #(.NUM_TAGS(NT), .NUM_LD_CH(1))   bus_ns ();

  tag_pipe_sync #(
    .NUM_TAGS(NT), .NUM_LD_CH(LDC), .STORE_ENABLED(1'b1), .REUSE_CNT_W(3)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  tag_pipe_sync #(
    .NUM_TAGS(NT), .NUM_LD_CH(1), .STORE_ENABLED(1'b0), .REUSE_CNT_W(3)
  ) u_dut_ns (
    .clk(clk), .reset_n(reset_n), .bus(bus_ns.slave)
  );

  // Hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Set the inputs at the falling edge and let the combinational outputs settle
  task automatic drive(input logic req, input logic reuse, input logic [LDC-1:0] ld,
                       input logic cd, input logic sd);
    @(negedge clk);
    bus.alloc_req   = req;
    bus.alloc_reuse = reuse;
    bus.ld_done     = ld;
    bus.cmp_done    = cd;
    bus.st_done     = sd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Request a tag. The expected grant is queued, then checked when it is offered.
  task automatic alloc(input logic reuse, input logic cd,
                       input logic [TW-1:0] exp_tag, input logic exp_hit);
    grant_t g;
    grant_q.push_back('{exp_tag, exp_hit});
    drive(1'b1, reuse, '0, cd, 1'b0);
    check("alloc_ready", 32'(bus.alloc_ready), 1);
    if (bus.alloc_ready && grant_q.size() > 0) begin
      g = grant_q.pop_front();
      check("alloc_tag", 32'(bus.alloc_tag), 32'(g.tag));
      check("alloc_hit", 32'(bus.alloc_hit), 32'(g.hit));
    end
  endtask

  task automatic check_reset_outputs(input string ctx);
    check({ctx, "_alloc_ready"}, 32'(bus.alloc_ready), 1);
    check({ctx, "_alloc_tag"},   32'(bus.alloc_tag),   0);
    check({ctx, "_alloc_hit"},   32'(bus.alloc_hit),   0);
    check({ctx, "_ld_ready"},    32'(bus.ld_ready),    0);
    check({ctx, "_cmp_ready"},   32'(bus.cmp_ready),   0);
    check({ctx, "_st_ready"},    32'(bus.st_ready),    0);
    check({ctx, "_occupancy"},   32'(bus.occupancy),   0);
    check({ctx, "_all_idle"},    32'(bus.all_idle),    1);
  endtask

  // Wait (bounded) until the compute stage offers a tag
  task automatic wait_cmp_ready();
    int n = 0;
    while (!bus.cmp_ready && n < 20) begin
      idle();
      n++;
    end
    check("cmp_ready_wait", 32'(bus.cmp_ready), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.alloc_req = 1'b0; bus.alloc_reuse = 1'b0; bus.ld_done = '0;
    bus.cmp_done  = 1'b0; bus.st_done     = 1'b0;
    bus_ns.alloc_req = 1'b0; bus_ns.alloc_reuse = 1'b0; bus_ns.ld_done = '0;
    bus_ns.cmp_done  = 1'b0; bus_ns.st_done     = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("ns_rst_all_idle", 32'(bus_ns.all_idle), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Two tags fill up and a third request stalls
    alloc(1'b0, 1'b0, 0, 1'b0);
    alloc(1'b0, 1'b0, 1, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("full_alloc_ready", 32'(bus.alloc_ready), 0);
    check("full_occupancy",   32'(bus.occupancy),   2);
    check("full_all_idle",    32'(bus.all_idle),    0);
    check("full_ld_ready",    32'(bus.ld_ready),    1);
    check("full_ld_tag",      32'(bus.ld_tag),      0);
    drive(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    idle();
    check("midload_ld_ready",  32'(bus.ld_ready),  1);
    check("midload_cmp_ready", 32'(bus.cmp_ready), 0);

    // Reset mid-load, between clock edges
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    reset_n = 1'b1;

    // One allocation and two reuses, then the three-channel load in scrambled order
    alloc(1'b0, 1'b0, 0, 1'b0);
    alloc(1'b1, 1'b0, 0, 1'b1);
    alloc(1'b1, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    check("reuse_occupancy", 32'(bus.occupancy), 1);
    check("reuse_alloc_tag", 32'(bus.alloc_tag), 1);
    drive(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    check("ld1_ld_ready",  32'(bus.ld_ready),  1);
    check("ld1_cmp_ready", 32'(bus.cmp_ready), 0);
    drive(1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    check("ld1r_cmp_ready", 32'(bus.cmp_ready), 0);
    drive(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    check("ld2_ld_ready",  32'(bus.ld_ready),  1);
    check("ld2_cmp_ready", 32'(bus.cmp_ready), 0);
    idle();
    check("ld3_cmp_ready", 32'(bus.cmp_ready), 1);
    check("ld3_cmp_tag",   32'(bus.cmp_tag),   0);
    check("ld3_ld_ready",  32'(bus.ld_ready),  0);
    check("ld3_ld_tag",    32'(bus.ld_tag),    1);

    // Three compute passes are needed before the store stage is offered
    store_q.push_back(TW'(0));
    for (int k = 1; k <= 3; k++) begin
      wait_cmp_ready();
      idle();
      check("cmp_started", 32'(bus.cmp_ready), 0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      idle();
      check($sformatf("st_ready_after_pass%0d", k), 32'(bus.st_ready), (k == 3) ? 1 : 0);
    end
    if (bus.st_ready && store_q.size() > 0) begin
      check("st_tag", 32'(bus.st_tag), 32'(store_q.pop_front()));
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("stored_all_idle",  32'(bus.all_idle),  1);
    check("stored_occupancy", 32'(bus.occupancy), 0);

    // A reuse coinciding with the last pending cmp_done keeps the count at 1
    alloc(1'b0, 1'b0, 1, 1'b0);
    drive(1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
    check("t1_ld_tag", 32'(bus.ld_tag), 1);
    idle();
    check("t1_cmp_ready", 32'(bus.cmp_ready), 1);
    check("t1_cmp_tag",   32'(bus.cmp_tag),   1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("t1_computing", 32'(bus.cmp_ready), 0);
    alloc(1'b1, 1'b1, 1, 1'b1);
    check("ignored_st_done_occ", 32'(bus.occupancy), 1);
    idle();
    check("net_cmp_ready", 32'(bus.cmp_ready), 1);
    check("net_cmp_tag",   32'(bus.cmp_tag),   1);
    check("net_st_ready",  32'(bus.st_ready),  0);
    idle();
    check("net_computing", 32'(bus.cmp_ready), 0);
    store_q.push_back(TW'(1));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();
    check("net_st_ready_final", 32'(bus.st_ready), 1);
    if (bus.st_ready && store_q.size() > 0) begin
      check("net_st_tag", 32'(bus.st_tag), 32'(store_q.pop_front()));
    end

    // A reuse of a tag already in STORE misses, and a STORE tag is not reallocated
    alloc(1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("store_block_ready", 32'(bus.alloc_ready), 0);
    check("store_block_tag",   32'(bus.alloc_tag),   1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle();
    check("store_freed_ready", 32'(bus.alloc_ready), 1);
    check("store_freed_occ",   32'(bus.occupancy),   1);

    // Counter saturation: at cnt=7 a reuse falls back to a fresh tag
    idle();
    #1;
    reset_n = 1'b0;
    #1;
    check("sat_rst_occ", 32'(bus.occupancy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    alloc(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      alloc(1'b1, 1'b0, 0, 1'b1);
    end
    alloc(1'b1, 1'b0, 1, 1'b0);
    idle();
    check("sat_occupancy", 32'(bus.occupancy), 2);

    // STORE_ENABLED=0: the tag frees straight after its last cmp_done
    @(negedge clk);
    bus_ns.alloc_req = 1'b1;
    #1;
    check("ns_alloc_ready", 32'(bus_ns.alloc_ready), 1);
    check("ns_alloc_tag",   32'(bus_ns.alloc_tag),   0);
    @(negedge clk);
    bus_ns.alloc_req = 1'b0;
    bus_ns.ld_done   = 1'b1;
    #1;
    check("ns_ld_ready", 32'(bus_ns.ld_ready), 1);
    @(negedge clk);
    bus_ns.ld_done = 1'b0;
    #1;
    check("ns_cmp_ready", 32'(bus_ns.cmp_ready), 1);
    @(negedge clk);
    bus_ns.cmp_done = 1'b1;
    #1;
    check("ns_computing", 32'(bus_ns.cmp_ready), 0);
    @(negedge clk);
    bus_ns.cmp_done    = 1'b0;
    bus_ns.alloc_reuse = 1'b1;
    #1;
    check("ns_all_idle",  32'(bus_ns.all_idle),  1);
    check("ns_occupancy", 32'(bus_ns.occupancy), 0);
    check("ns_st_ready",  32'(bus_ns.st_ready),  0);
    check("ns_reuse_hit", 32'(bus_ns.alloc_hit), 0);
    check("ns_reuse_tag", 32'(bus_ns.alloc_tag), 1);
    bus_ns.alloc_reuse = 1'b0;

    // Every queued expectation should have been consumed
    check("grant_q_drained", 32'(grant_q.size()), 0);
    check("store_q_drained", 32'(store_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tag_pipe_sync.md
TAG_PIPE_SYNC -- requirements
Module: tag_pipe_sync

Interface
REQ-001 The block SHALL have parameter NUM_TAGS, default 2: number of buffer tags, legal range 2..16.
REQ-002 The block SHALL have parameter TAG_W, default $clog2(NUM_TAGS): tag index width.
REQ-003 The block SHALL have parameter NUM_LD_CH, default 1: number of load channels that must all finish a tag, legal range 1..8.
REQ-004 The block SHALL have parameter STORE_ENABLED, default 1: when 0, the STORE stage is skipped.
REQ-005 The block SHALL have parameter REUSE_CNT_W, default 3: width of the per-tag pending-compute counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port alloc_req, input, 1 bit: producer requests a tag.
REQ-009 The block SHALL have port alloc_reuse, input, 1 bit: producer asks to reuse the previously allocated tag.
REQ-010 The block SHALL have port alloc_ready, output, 1 bit: the request can be accepted this cycle.
REQ-011 The block SHALL have port alloc_tag, output, TAG_W bits: the tag granted on accept.
REQ-012 The block SHALL have port alloc_hit, output, 1 bit: the grant reuses resident data, so no load is needed.
REQ-013 The block SHALL have ports ld_done (input, NUM_LD_CH bits), ld_ready (output, 1 bit) and ld_tag (output, TAG_W bits): the load stage.
REQ-014 The block SHALL have ports cmp_done (input, 1 bit), cmp_ready (output, 1 bit) and cmp_tag (output, TAG_W bits): the compute stage.
REQ-015 The block SHALL have ports st_done (input, 1 bit), st_ready (output, 1 bit) and st_tag (output, TAG_W bits): the store stage.
REQ-016 The block SHALL have port occupancy, output, $clog2(NUM_TAGS+1) bits: count of non-FREE tags.
REQ-017 The block SHALL have port all_idle, output, 1 bit: every tag is FREE.

Function
REQ-018 Each tag SHALL hold a state FREE, LOAD, CMP_RDY, COMPUTE or STORE, plus a pending-compute counter cnt.
REQ-019 Pointers alloc_ptr, ld_ptr, cmp_ptr and st_ptr SHALL each advance modulo NUM_TAGS, 0 following NUM_TAGS-1, so tags are used strictly in order.
REQ-020 A reuse hit SHALL be defined as alloc_reuse && prev_valid && state[prev_tag] in {LOAD, CMP_RDY, COMPUTE} && cnt[prev_tag] < 2^REUSE_CNT_W-1.
REQ-021 On a hit: alloc_hit=1, alloc_tag=prev_tag, alloc_ready=1; on accept, cnt[prev_tag] increments and neither the state nor alloc_ptr changes.
REQ-022 On a non-hit (including a reuse request that fails REQ-020): alloc_hit=0, alloc_tag=alloc_ptr, alloc_ready=(state[alloc_ptr]==FREE).
REQ-023 A non-hit accept SHALL set state to LOAD, cnt to 1, prev_tag to alloc_ptr and prev_valid to 1, and SHALL advance alloc_ptr.
REQ-024 An accept SHALL be alloc_req && alloc_ready, and state changes SHALL be visible from the next cycle.
REQ-025 ld_tag SHALL equal ld_ptr and ld_ready SHALL equal (state[ld_ptr]==LOAD).
REQ-026 ld_done bits SHALL accumulate in an ld_mask register only while ld_ready=1.
REQ-027 When (ld_mask | ld_done) is all ones, the tag SHALL move to CMP_RDY, ld_mask SHALL clear and ld_ptr SHALL advance in that same edge.
REQ-028 Repeated ld_done bits on the same channel SHALL be harmless.
REQ-029 cmp_tag SHALL equal cmp_ptr and cmp_ready SHALL equal (state[cmp_ptr]==CMP_RDY).
REQ-030 The edge on which cmp_ready is sampled high SHALL move the tag to COMPUTE.
REQ-031 cmp_done in COMPUTE SHALL decrement cnt; if the result is >0 the tag SHALL return to CMP_RDY.
REQ-032 If the decremented cnt is 0, the tag SHALL move to STORE (or to FREE if STORE_ENABLED=0) and cmp_ptr SHALL advance.
REQ-033 A simultaneous reuse accept and cmp_done on the same tag SHALL apply the net cnt change, so cnt is unchanged and the tag returns to CMP_RDY.
REQ-034 st_tag SHALL equal st_ptr and st_ready SHALL equal (state[st_ptr]==STORE); st_done while st_ready=1 SHALL free the tag and advance st_ptr.
REQ-035 cmp_done and st_done arriving while the corresponding ready is low SHALL be ignored.
REQ-036 When STORE_ENABLED=0, st_ready SHALL be held at 0.
REQ-037 occupancy and all_idle SHALL be combinational from the state array.
REQ-038 A tag in STORE SHALL never be reallocated until it is FREE.

Reset
REQ-039 While reset_n=0, all tags SHALL be FREE with cnt=0, all pointers, ld_mask and prev_tag SHALL be 0, and prev_valid SHALL be 0.
REQ-040 Reset values SHALL be alloc_ready=1, alloc_tag=0, alloc_hit=0, ld/cmp/st_ready=0, occupancy=0, all_idle=1.
REQ-041 Reset asserted mid-operation SHALL discard all in-flight tags immediately, without waiting for a clock edge.

Verification
REQ-042 NUM_TAGS=2: three non-reuse requests with no done inputs -> tags 0 and 1 granted, third stalled (alloc_ready=0), occupancy=2.
REQ-043 NUM_LD_CH=3: ld_done=001, then 100, then 010 -> tag moves to CMP_RDY only after the third pulse; cmp_ready=1 the following cycle.
REQ-044 Allocate tag0, then issue two reuse requests, then run compute on tag0 -> alloc_hit=1 and tag=0 on both reuses; cmp_done must occur 3 times before st_ready=1.
REQ-045 Reuse request asserted on the same cycle cnt=1 receives cmp_done -> tag returns to CMP_RDY with cnt=1; no store is issued.
REQ-046 Reuse request after the previous tag reached STORE -> alloc_hit=0 and a fresh tag is granted; with STORE_ENABLED=0 the tag goes FREE directly after cmp_done.
REQ-047 reset_n driven low mid-load with 2 tags busy -> all outputs return to their REQ-040 values asynchronously.
